mandel_pixel_stream: RTL
========================

# mandel_pixel_stream

Downstream stage of the per-pixel colour generator: accepts 8-bit r/g/b samples through a valid/ready handshake and emits them as a raster-ordered AXI4-Stream video stream for the display/VDMA path. Buffers pixels in a small FIFO to absorb sink back-pressure. Marks start-of-frame on `tuser` and end-of-line on `tlast` from internal column/row counters. A run/stop control ends streaming cleanly on a frame boundary.

## Interface
- `H_ACTIVE`, 640: active pixels per line, ≥ 2.
- `V_ACTIVE`, 480: active lines per frame, ≥ 1.
- `FIFO_DEPTH`, 4: pixel FIFO entries; power of two, ≥ 2.
- `aclk` in 1: single clock; all logic is on its rising edge.
- `clr` in 1: reset, asynchronous and active-high.
- `run` in 1: level; 1 = stream frames, 0 = stop at the next frame boundary.
- `in_valid` in 1: r/g/b hold a pixel.
- `in_ready` out 1: block accepts a pixel this cycle.
- `r`, `g`, `b` in 8 each: pixel colour components.
- `m_axis_tdata` out 24: pixel, packed as {r, g, b}, with r in [23:16].
- `m_axis_tvalid` out 1: output pixel valid.
- `m_axis_tready` in 1: sink accepts.
- `m_axis_tuser` out 1: first pixel of frame (x=0, y=0).
- `m_axis_tlast` out 1: last pixel of line (x=H_ACTIVE-1).
- `frame_done` out 1: one-cycle pulse after the last pixel of a frame transfers.
- `busy` out 1: state ≠ IDLE, or FIFO not empty.

## Operation
- Input transfer: `in_valid && in_ready`. Output transfer: `m_axis_tvalid && m_axis_tready`.
- States:
  - IDLE: `in_ready`=0. Go to RUN when `run`=1.
  - RUN: `in_ready` = !full. Count accepted pixels with `in_x`/`in_y`. When the last pixel of a frame is accepted and `run`=0, go to DRAIN. If `run`=1 at that point, stay in RUN.
  - DRAIN: `in_ready`=0. Go to IDLE when the FIFO is empty and the output counters are at 0,0.
- `run` dropping mid-frame has no effect until that frame's last pixel is accepted. Frames are never truncated.
- Output counters:
  - `out_x` (width $clog2(H_ACTIVE)) increments on each output transfer and wraps to 0 at H_ACTIVE-1.
  - `out_y` (width $clog2(V_ACTIVE)) increments on that wrap and wraps to 0 at V_ACTIVE-1.
- `tuser` and `tlast` are decoded from the output counters of the head pixel. They are valid only while `tvalid`=1, and 0 otherwise.
- `frame_done` is registered. It is 1 in the cycle after the output transfer with out_x=H_ACTIVE-1 and out_y=V_ACTIVE-1.
- FIFO full: `in_ready`=0 even if a pop happens in the same cycle (no pass-through on full).
- FIFO empty: `tvalid`=0. No combinational path from input to output.
- Simultaneous push and pop when not full: occupancy is unchanged and order is preserved.
- `tdata` and `tvalid` hold stable while `tvalid`=1 and `tready`=0.

## Timing
- Reset values: `in_ready`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tuser`=0, `m_axis_tlast`=0, `frame_done`=0, `busy`=0. State=IDLE, all counters 0, FIFO empty.
- `clr` asserted mid-operation clears everything immediately (asynchronous). Buffered pixels are discarded. The next frame restarts at 0,0 with `tuser`.
- IDLE→RUN: `in_ready` rises one cycle after `run` is sampled high.
- Latency: a pixel accepted in cycle N is visible on `m_axis_tdata` with `tvalid`=1 in cycle N+1 if the FIFO was empty.
- Throughput: 1 pixel/cycle sustained while `tready`=1.
- `in_ready` depends only on registered state, never on `m_axis_tready`.

## Structure
- Shared package `mandel_video_pkg`:
  - `rgb24_t` packed {r, g, b}.
  - Default `H_ACTIVE`/`V_ACTIVE` constants.
  - State enum `stream_state_t` {IDLE, RUN, DRAIN}.
- One sub-module: `pixel_fifo`, a synchronous FIFO.
  - Parameters: width, depth.
  - Ports: push/pop/full/empty, registered read output.
  - Same clock and asynchronous `clr`.
- Top level holds the FSM, input/output raster counters and the `tuser`/`tlast`/`frame_done` decode.

## Test plan
- H_ACTIVE=4, V_ACTIVE=2, `run`=1, `tready`=1, 8 pixels with values 0x000001..0x000008 → out in order. `tuser` on 0x000001 only. `tlast` on pixels 4 and 8. `frame_done` 1 cycle after pixel 8.
- `tready`=0 with `in_valid`=1 constant → `in_ready` falls after 4 accepts (FIFO_DEPTH=4). `tdata`/`tvalid` stay stable. Release `tready` → 4 pixels drain in order with no loss.
- `run` deasserted after pixel 3 of an 8-pixel frame → all 8 pixels are emitted, then DRAIN→IDLE, `busy`=0, `in_ready` stays 0.
- `clr` pulse with 3 pixels buffered mid-line → `tvalid` is 0 in the same cycle. After restart, the first pixel out has `tuser`=1 and x=0.
- Random `tready` (50%) over 3 back-to-back frames → scoreboard matches, one `tuser` per 8 pixels, 3 `frame_done` pulses.

Source files
------------

// File: rtl/mandel_video_pkg.sv
// Shared video types for the Mandelbrot pixel path: packed RGB sample,
// default raster size and the stream controller states.
package mandel_video_pkg;

    localparam int DEFAULT_H_ACTIVE = 640;
    localparam int DEFAULT_V_ACTIVE = 480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } stream_state_t;

endpackage

// File: rtl/mandel_pixel_stream_fifo.sv
// Small synchronous show-ahead FIFO: the head entry is always presented on
// a registered read port, so a push into an empty FIFO is visible next cycle.
module pixel_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             aclk,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full        = (count == (AW+1)'(DEPTH));
    assign empty       = (count == '0);
    assign push_ok     = push && !full;
    assign pop_ok      = pop && !empty;
    assign rd_ptr_next = pop_ok ? rd_ptr + AW'(1) : rd_ptr;

    always_ff @(posedge aclk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // The read register tracks the entry that will be at the head after this
    // edge; a same-cycle write to that slot is forwarded from wr_data.
    always_ff @(posedge aclk or posedge clr) begin
        if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_next;
            if (push_ok && !pop_ok) begin
                count <= count + (AW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - (AW+1)'(1);
            end
            if (push_ok || pop_ok) begin
                rd_data <= (push_ok && (wr_ptr == rd_ptr_next)) ? wr_data : mem[rd_ptr_next];
            end
        end
    end

endmodule

// File: rtl/mandel_pixel_stream.sv
// Converts handshaked RGB pixels into a raster-ordered AXI4-Stream video
// stream with tuser/tlast framing and a frame-boundary run/stop control.
module mandel_pixel_stream #(
    parameter int H_ACTIVE   = mandel_video_pkg::DEFAULT_H_ACTIVE,
    parameter int V_ACTIVE   = mandel_video_pkg::DEFAULT_V_ACTIVE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        aclk,
    input  logic        clr,
    input  logic        run,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        frame_done,
    output logic        busy
);

    import mandel_video_pkg::*;

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    stream_state_t state;
    stream_state_t state_next;

    rgb24_t        in_pix;
    rgb24_t        head_pix;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [XW-1:0] in_x;
    logic [YW-1:0] in_y;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          in_last;
    logic          out_line_end;
    logic          out_frame_end;

    assign in_pix   = {r, g, b};
    assign in_ready = (state == RUN) && !full;
    assign push     = in_valid && in_ready;
    assign pop      = !empty && m_axis_tready;

    assign in_last       = (in_x == X_LAST) && (in_y == Y_LAST);
    assign out_line_end  = (out_x == X_LAST);
    assign out_frame_end = out_line_end && (out_y == Y_LAST);

    pixel_fifo #(
        .WIDTH ($bits(rgb24_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .clr     (clr),
        .push    (push),
        .wr_data (in_pix),
        .pop     (pop),
        .rd_data (head_pix),
        .full    (full),
        .empty   (empty)
    );

    assign m_axis_tdata  = head_pix;
    assign m_axis_tvalid = !empty;
    assign m_axis_tuser  = !empty && (out_x == '0) && (out_y == '0);
    assign m_axis_tlast  = !empty && out_line_end;
    assign busy          = (state != IDLE) || !empty;

    always_ff @(posedge aclk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stopping is only honoured once a whole frame has been accepted, and the
    // controller idles only after that frame has fully left the FIFO.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (run) state_next = RUN;
            RUN:     if (push && in_last && !run) state_next = DRAIN;
            DRAIN:   if (empty && (out_x == '0) && (out_y == '0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge clr) begin
        if (clr) begin
            in_x       <= '0;
            in_y       <= '0;
            out_x      <= '0;
            out_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            if (push) begin
                if (in_x == X_LAST) begin
                    in_x <= '0;
                    in_y <= (in_y == Y_LAST) ? '0 : in_y + YW'(1);
                end else begin
                    in_x <= in_x + XW'(1);
                end
            end
            if (pop) begin
                if (out_line_end) begin
                    out_x <= '0;
                    out_y <= (out_y == Y_LAST) ? '0 : out_y + YW'(1);
                end else begin
                    out_x <= out_x + XW'(1);
                end
            end
            frame_done <= pop && out_frame_end;
        end
    end

endmodule
